// File: rtl/l1_port_arbiter_pkg.sv
// Shared types for the L1 port arbiter: FSM states, grant identity and the
// request tuple captured per requester.
package l1_port_arbiter_pkg;

  localparam int TUP_AW = 32;
  localparam int TUP_DW = 32;

  typedef enum logic [1:0] {
    IDLE,
    LOCK_I,
    LOCK_D
  } arb_state_e;

  typedef enum logic {
    GNT_I,
    GNT_D
  } grant_e;

  typedef struct packed {
    logic [TUP_AW-1:0] addr;
    logic              we;
    logic [TUP_DW-1:0] wdata;
    logic [3:0]        mask;
  } req_tuple_t;

endpackage

// File: rtl/l1_port_arbiter_req_hold.sv
// Per-requester result hold: remembers the last completed tuple and its data so
// a requester that keeps presenting the same tuple is served without memory.
module req_hold
  import l1_port_arbiter_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req_i,
  input  req_tuple_t    tuple_i,
  input  logic          load_i,
  input  req_tuple_t    load_tuple_i,
  input  logic [DW-1:0] load_data_i,
  input  logic          clr_i,
  output logic          served_o,
  output logic [DW-1:0] data_o
);

  logic          valid_q, valid_d;
  req_tuple_t    tuple_q, tuple_d;
  logic [DW-1:0] data_q, data_d;
  logic          hit;

  assign hit      = (tuple_q == tuple_i);
  assign served_o = valid_q && hit && req_i;
  assign data_o   = data_q;

  // A load always wins: the winner of a completion cannot also be the target
  // of the write-clear in the same cycle.
  always_comb begin
    valid_d = valid_q;
    tuple_d = tuple_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      tuple_d = load_tuple_i;
      data_d  = load_data_i;
    end else if (clr_i || !req_i || !hit) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    tuple_q <= tuple_d;
    data_q  <= data_d;
  end

endmodule

// File: rtl/l1_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access:
// data has priority, fetch is forced after MAX_D_STREAK consecutive data grants.
module l1_port_arbiter
  import l1_port_arbiter_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] Iaddr,
  input  logic          Imemaccess,
  output logic [DW-1:0] Iinstn,
  output logic          Iwait,
  input  logic [AW-1:0] Daddr,
  input  logic          Dwe,
  input  logic [DW-1:0] Dwritedata,
  input  logic [3:0]    dmem_mask,
  input  logic          Dmemaccess,
  output logic [DW-1:0] Dreaddata,
  output logic          Dwait,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-3:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_mask,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  arb_state_e    state_q;
  req_tuple_t    lock_tup_q;
  logic [3:0]    d_streak_q;

  logic          i_req, d_req;
  logic          i_served, d_served;
  logic          i_pend, d_pend;
  req_tuple_t    i_tup, d_tup, gnt_tup;
  grant_e        gnt;
  logic          gnt_vld;
  logic          complete, i_done, d_done, i_done_hit, d_done_hit;
  logic [DW-1:0] i_hold_data, d_hold_data;
  logic          unused_addr_lsb;

  assign i_req = Imemaccess;
  assign d_req = Dmemaccess | Dwe;

  always_comb begin
    i_tup       = '0;
    i_tup.addr  = TUP_AW'(Iaddr);
    d_tup       = '0;
    d_tup.addr  = TUP_AW'(Daddr);
    d_tup.we    = Dwe;
    d_tup.wdata = TUP_DW'(Dwritedata);
    d_tup.mask  = dmem_mask;
  end

  assign i_pend = i_req && !i_served;
  assign d_pend = d_req && !d_served;

  // In IDLE the winner drives memory directly so a ready memory completes with
  // zero wait; once locked, the captured tuple keeps the bus stable.
  always_comb begin
    gnt     = GNT_D;
    gnt_vld = 1'b0;
    gnt_tup = d_tup;
    case (state_q)
      LOCK_I: begin
        gnt     = GNT_I;
        gnt_vld = 1'b1;
        gnt_tup = lock_tup_q;
      end
      LOCK_D: begin
        gnt     = GNT_D;
        gnt_vld = 1'b1;
        gnt_tup = lock_tup_q;
      end
      default: begin
        if (d_pend && !(i_pend && d_streak_q == STREAK_MAX)) begin
          gnt     = GNT_D;
          gnt_vld = 1'b1;
          gnt_tup = d_tup;
        end else if (i_pend) begin
          gnt     = GNT_I;
          gnt_vld = 1'b1;
          gnt_tup = i_tup;
        end
      end
    endcase
  end

  assign mem_req         = gnt_vld && rst_n;
  assign mem_we          = gnt_tup.we;
  assign mem_addr        = gnt_tup.addr[AW-1:2];
  assign mem_wdata       = gnt_tup.wdata[DW-1:0];
  assign mem_mask        = gnt_tup.mask;
  assign unused_addr_lsb = ^gnt_tup.addr[1:0];

  assign complete = mem_req && mem_ready;
  assign i_done   = complete && (gnt == GNT_I);
  assign d_done   = complete && (gnt == GNT_D);

  // A locked result only satisfies the requester if it still asks for it.
  assign i_done_hit = i_done && i_req && (gnt_tup == i_tup);
  assign d_done_hit = d_done && d_req && (gnt_tup == d_tup);

  assign Iwait     = i_req && !i_served && !i_done_hit;
  assign Dwait     = d_req && !d_served && !d_done_hit;
  assign Iinstn    = i_done_hit ? mem_rdata : (i_served ? i_hold_data : '0);
  assign Dreaddata = d_done_hit ? mem_rdata : (d_served ? d_hold_data : '0);

  req_hold #(.DW(DW)) u_i_hold (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_i        (i_req),
    .tuple_i      (i_tup),
    .load_i       (i_done),
    .load_tuple_i (gnt_tup),
    .load_data_i  (mem_rdata),
    .clr_i        (d_done && gnt_tup.we),
    .served_o     (i_served),
    .data_o       (i_hold_data)
  );

  req_hold #(.DW(DW)) u_d_hold (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_i        (d_req),
    .tuple_i      (d_tup),
    .load_i       (d_done),
    .load_tuple_i (gnt_tup),
    .load_data_i  (mem_rdata),
    .clr_i        (1'b0),
    .served_o     (d_served),
    .data_o       (d_hold_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lock_tup_q <= '0;
      d_streak_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_vld && !mem_ready) begin
            state_q    <= (gnt == GNT_I) ? LOCK_I : LOCK_D;
            lock_tup_q <= gnt_tup;
          end
        end
        LOCK_I, LOCK_D: begin
          if (mem_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (i_done || !i_pend) begin
        d_streak_q <= '0;
      end else if (d_done && d_streak_q != STREAK_MAX) begin
        d_streak_q <= d_streak_q + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_l1_port_arbiter.sv
// Bench for l1_port_arbiter: directed scenarios plus randomized core traffic
// checked against an architectural memory image and fairness/liveness rules.
module tb_l1_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXS = 4;
  localparam int NW   = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] Iaddr, Daddr;
  logic          Imemaccess, Dwe, Dmemaccess;
  logic [DW-1:0] Dwritedata;
  logic [3:0]    dmem_mask;
  logic [DW-1:0] Iinstn, Dreaddata, mem_wdata, mem_rdata;
  logic          Iwait, Dwait, mem_req, mem_we, mem_ready;
  logic [AW-3:0] mem_addr;
  logic [3:0]    mem_mask;

  logic [31:0] bmem [NW];
  logic [31:0] rmem [NW];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  l1_port_arbiter #(.AW(AW), .DW(DW), .MAX_D_STREAK(MAXS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Iaddr      (Iaddr),
    .Imemaccess (Imemaccess),
    .Iinstn     (Iinstn),
    .Iwait      (Iwait),
    .Daddr      (Daddr),
    .Dwe        (Dwe),
    .Dwritedata (Dwritedata),
    .dmem_mask  (dmem_mask),
    .Dmemaccess (Dmemaccess),
    .Dreaddata  (Dreaddata),
    .Dwait      (Dwait),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_mask   (mem_mask),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  assign mem_rdata = bmem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (mem_req && mem_ready && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_mask[b]) bmem[mem_addr[7:0]][8*b +: 8] = mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] m);
    merge = old;
    for (int b = 0; b < 4; b++)
      if (m[b]) merge[8*b +: 8] = d[8*b +: 8];
  endfunction

  task automatic put(input int idx, input logic [31:0] v);
    bmem[idx] = v;
    rmem[idx] = v;
  endtask

  task automatic idle_in();
    Imemaccess = 1'b0; Iaddr = '0;
    Dmemaccess = 1'b0; Dwe = 1'b0; Daddr = '0; Dwritedata = '0; dmem_mask = '0;
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic settle();
    #2;
  endtask

  // A store the core sees finish (Dwait low) is architecturally done.
  task automatic ref_store();
    if (Dwe && !Dwait)
      rmem[Daddr[9:2]] = merge(rmem[Daddr[9:2]], Dwritedata, dmem_mask);
  endtask

  logic        iw, dw, lk;
  logic [35:0] lk_ctl;
  logic [31:0] lk_wd;
  int          icnt, dcnt, scnt, r, nreq, iw_cnt;

  initial begin
    for (int i = 0; i < NW; i++) put(i, $urandom);
    idle_in();
    mem_ready  = 1'b0;
    rst_n      = 1'b0;
    Imemaccess = 1'b1;
    Dmemaccess = 1'b1;
    Daddr      = 32'h4;
    #2;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_iwait", Iwait, 1);
    chk("rst_dwait", Dwait, 1);
    chk("rst_data", {Iinstn, Dreaddata}, 0);
    nxt();
    rst_n = 1'b1;
    idle_in();

    // lone fetch, zero-wait memory
    nxt();
    put(32'h40, 32'hDEADBEEF);
    mem_ready = 1'b1; Imemaccess = 1'b1; Iaddr = 32'h100;
    settle();
    chk("zw_iwait", Iwait, 0);
    chk("zw_inst", Iinstn, 32'hDEADBEEF);
    chk("zw_addr", mem_addr, 32'h40);
    chk("zw_req", mem_req, 1);
    nxt();
    idle_in();
    settle();
    chk("noreq_out", {Iwait, Dwait, Iinstn, Dreaddata}, 0);

    // simultaneous I and D, memory answers two cycles after each request
    nxt();
    put(0, 32'hA5A5_0001);
    put(32'h80, 32'h5A5A_0002);
    Imemaccess = 1'b1; Iaddr = 32'h0;
    Dmemaccess = 1'b1; Daddr = 32'h200; dmem_mask = 4'hF;
    iw_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) nxt();
      mem_ready = (c == 2 || c == 5);
      settle();
      iw_cnt += int'(Iwait);
      if (c == 0) chk("sim_first_addr", mem_addr, 32'h80);
      if (c < 2) chk("sim_dwait_hi", Dwait, 1);
      if (c == 2) chk("sim_d_done", {Dwait, Dreaddata}, {1'b0, 32'h5A5A_0002});
      if (c == 3) chk("sim_i_addr", {mem_req, mem_addr}, {1'b1, 30'h0});
      if (c == 5) chk("sim_i_done", {Iwait, Iinstn}, {1'b0, 32'hA5A5_0001});
      if (c == 5) chk("sim_d_held", {Dwait, Dreaddata}, {1'b0, 32'h5A5A_0002});
    end
    chk("sim_iwait_cycles", iw_cnt, 5);

    // D streak with a pending fetch
    nxt(); idle_in(); settle();
    nxt();
    mem_ready = 1'b1; Imemaccess = 1'b1; Iaddr = 32'h40;
    dw = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) nxt();
      if (!dw) begin
        Dwe = 1'b1; Daddr = 32'h380 + 32'(c * 4); Dwritedata = $urandom; dmem_mask = 4'hF;
      end
      settle();
      chk("streak_iwait", Iwait, c < 4);
      chk("streak_dwait", Dwait, c == 4);
      if (c == 4) chk("streak_inst", Iinstn, rmem[16]);
      if (c == 5) chk("streak_clr", dut.d_streak_q, 0);
      dw = Dwait;
      ref_store();
    end

    // fetch held for three cycles costs one transaction
    nxt(); idle_in(); settle();
    nxt();
    mem_ready = 1'b1; Imemaccess = 1'b1; Iaddr = 32'h10;
    nreq = 0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) nxt();
      settle();
      nreq += int'(mem_req);
      chk("hold_iwait", Iwait, 0);
      chk("hold_inst", Iinstn, rmem[4]);
    end
    chk("hold_one_txn", nreq, 1);

    // store to fetched word clears the fetch hold
    nxt(); idle_in(); settle();
    nxt();
    mem_ready = 1'b1; Imemaccess = 1'b1; Iaddr = 32'h300;
    settle();
    chk("smc_fetch", {Iwait, Iinstn}, {1'b0, rmem[32'hC0]});
    nxt();
    Dwe = 1'b1; Daddr = 32'h300; Dwritedata = 32'h12345678; dmem_mask = 4'b0011;
    settle();
    chk("smc_store", {Dwait, Iwait, mem_we}, 3'b001);
    ref_store();
    nxt();
    Dwe = 1'b0; Daddr = '0; Dwritedata = '0; dmem_mask = '0;
    settle();
    chk("smc_refetch", {mem_req, mem_we, mem_addr}, {2'b10, 30'hC0});
    chk("smc_inst", {Iwait, Iinstn}, {1'b0, rmem[32'hC0]});

    // reset while locked on a data load
    nxt(); idle_in(); settle();
    nxt();
    mem_ready = 1'b0; Dmemaccess = 1'b1; Daddr = 32'h200; dmem_mask = 4'hF;
    settle();
    chk("rl_issue", mem_req, 1);
    nxt(); settle();
    chk("rl_locked", {mem_req, mem_addr}, {1'b1, 30'h80});
    #1 rst_n = 1'b0;
    #1;
    chk("rl_async", {mem_req, Dwait, Dreaddata}, {2'b01, 32'h0});
    nxt();
    rst_n = 1'b1;
    settle();
    chk("rl_reissue", {mem_req, mem_addr, Dwait}, {1'b1, 30'h80, 1'b1});
    nxt();
    mem_ready = 1'b1;
    settle();
    chk("rl_done", {Dwait, Dreaddata}, {1'b0, rmem[32'h80]});

    // randomized core traffic
    nxt(); idle_in(); settle();
    iw = 1'b0; dw = 1'b0; lk = 1'b0; lk_ctl = '0; lk_wd = '0;
    icnt = 0; dcnt = 0; scnt = 0;
    for (int c = 0; c < 3000; c++) begin
      nxt();
      if (!iw) begin
        r = $urandom_range(7, 0);
        if (r < 2) Imemaccess = 1'b0;
        else if (r >= 4) begin
          Imemaccess = 1'b1;
          Iaddr = {26'd0, 4'($urandom_range(15, 0)), 2'b00};
        end
      end
      if (!dw) begin
        r = $urandom_range(7, 0);
        case (r)
          0, 1: begin Dmemaccess = 1'b0; Dwe = 1'b0; end
          3, 4: begin
            Dmemaccess = 1'b1; Dwe = 1'b0; Dwritedata = '0; dmem_mask = 4'hF;
            Daddr = {26'd0, 4'($urandom_range(15, 0)), 2'b00};
          end
          5, 6, 7: begin
            Dmemaccess = 1'b0; Dwe = 1'b1; Dwritedata = $urandom;
            dmem_mask = 4'($urandom_range(15, 0));
            Daddr = {26'd0, 4'($urandom_range(15, 0)), 2'b00};
          end
          default: ;
        endcase
      end
      mem_ready = (c >= 2000) || ($urandom_range(3, 0) != 0);
      settle();

      if (lk) begin
        chk("lock_ctl", {mem_req, mem_we, mem_mask, mem_addr}, lk_ctl);
        chk("lock_wdata", mem_wdata, lk_wd);
      end
      lk     = mem_req && !mem_ready;
      lk_ctl = {mem_req, mem_we, mem_mask, mem_addr};
      lk_wd  = mem_wdata;

      if (Imemaccess && !Iwait) chk("rnd_inst", Iinstn, rmem[Iaddr[9:2]]);
      if (!Imemaccess) chk("rnd_i_idle", {Iwait, Iinstn}, 0);
      if (Dmemaccess && !Dwe && !Dwait) chk("rnd_load", Dreaddata, rmem[Daddr[9:2]]);
      if (!Dmemaccess && !Dwe) chk("rnd_d_idle", {Dwait, Dreaddata}, 0);

      if (Iwait) begin
        if (mem_req && mem_ready) scnt++;
      end else begin
        scnt = 0;
      end
      chk("rnd_fairness", scnt <= MAXS, 1);
      icnt = Iwait ? icnt + 1 : 0;
      dcnt = Dwait ? dcnt + 1 : 0;
      chk("rnd_i_live", icnt < 60, 1);
      chk("rnd_d_live", dcnt < 60, 1);

      ref_store();
      iw = Iwait;
      dw = Dwait;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/l1_port_arbiter.md
Name: l1_port_arbiter

Overview:
- Shares one single-ported backing memory between the core's instruction-fetch requester and its data load/store requester.
- Sits between the core's memory bus signals and a single-port memory with a req/ready handshake.
- Generates Iwait/Dwait from arbitration and memory latency, and holds completed results until the requester moves on.
- Data side has priority, with a starvation guard for fetch.

Parameters:
- AW, 32, address width (word index = addr[AW-1:2])
- DW, 32, data width
- MAX_D_STREAK, 4, max consecutive D grants while fetch is pending before fetch is forced (1..15)

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- Iaddr  input  AW  fetch byte address
- Imemaccess  input  1  fetch request
- Iinstn  output  DW  fetched word
- Iwait  output  1  fetch not complete; core holds Iaddr
- Daddr  input  AW  data byte address
- Dwe  input  1  store
- Dwritedata  input  DW  store data
- dmem_mask  input  4  store byte enables
- Dmemaccess  input  1  load request
- Dreaddata  output  DW  load data
- Dwait  output  1  data access not complete
- mem_req  output  1  memory request
- mem_we  output  1  memory write
- mem_addr  output  AW-2  word index
- mem_wdata  output  DW  write data
- mem_mask  output  4  byte enables
- mem_rdata  input  DW  read data, valid in ready cycle
- mem_ready  input  1  transaction completes on edge where mem_req && mem_ready

Behaviour:
- Request definitions:
  - I_req = Imemaccess.
  - D_req = Dmemaccess | Dwe.
- Request capture: each requester's request is captured as a tuple:
  - I tuple = {Iaddr}.
  - D tuple = {Daddr, Dwe, Dwritedata, dmem_mask}.
- Hold registers: per requester, a valid bit, the tuple, and read data. A request is "served" when its hold is valid and its current tuple matches the held tuple.
- Waits: Xwait = X_req && !served && !(completing this cycle). No request means Xwait=0 and the data output is 0.
- Data outputs: the data output is mem_rdata in the completion cycle, the hold data while served, and 0 otherwise.
- FSM states: IDLE, LOCK_I, LOCK_D.
- IDLE:
  - Pick among unserved requests.
  - D wins unless I is pending and d_streak==MAX_D_STREAK.
  - Drive mem_* combinationally from the winner, with mem_we=Dwe for D and 0 for I.
  - If mem_ready, complete this cycle (zero-wait). Otherwise go to LOCK_<winner>.
- LOCK_x:
  - mem_* is driven from a registered copy of the granted tuple and stays stable.
  - On mem_ready, complete and return to IDLE.
  - A requester tuple change while locked does not abort the transaction. Its result loads the hold, but a mismatched hold is not served.
- Completion (edge):
  - Load the winner's hold: valid=1, tuple, mem_rdata.
  - A D write completion also clears I-hold valid (self-modifying code).
- Hold invalidation: a hold clears when its request deasserts or its tuple changes.
- Back-to-back requests: the earliest re-issue after completion is the next cycle in IDLE. Identical consecutive requests are served from the hold; this is idempotent by construction.
- d_streak (4-bit):
  - Increments on D completion while I_req is unserved, saturating at MAX_D_STREAK.
  - Clears on I completion or when I_req is not pending.
- Reset:
  - Asynchronous; takes effect mid-transaction.
  - State returns to IDLE, all holds are invalid, d_streak=0, registered tuple=0.
  - While rst_n=0: mem_req=0, Iwait=I_req, Dwait=D_req, Iinstn=Dreaddata=0.
  - An aborted transaction is not retried in reset; the request re-arbitrates after release.

Decomposition:
- A shared package holds:
  - the arb_state_e typedef (IDLE, LOCK_I, LOCK_D),
  - the req_tuple_t struct (addr, we, wdata, mask),
  - the grant_e typedef (GNT_I, GNT_D).
- Sub-module req_hold: one instance per requester, containing the hold register, tuple compare, served logic and clear-on-write input. The arbiter FSM and streak counter stay in the top module.

Test Plan:
- Zero-wait memory (mem_ready=1), lone fetch Iaddr=0x100 with mem_rdata=0xDEADBEEF -> Iwait=0, Iinstn=0xDEADBEEF same cycle, mem_addr=0x40.
- Simultaneous I (0x0) and D load (0x200), with mem_ready asserted 2 cycles after each req -> D served first (Dwait low in cycle 2), then I; Iwait high for 5 cycles.
- Continuous D stores to new addresses plus a pending fetch, MAX_D_STREAK=4, zero-wait memory -> exactly 4 D grants, then an I grant; d_streak returns to 0.
- Fetch completes while Dwait holds the pipeline; Iaddr is held 3 cycles -> one memory transaction only; Iwait=0 and Iinstn stable for all 3 cycles.
- Store 0x12345678 to 0x300 with mask 4'b0011 completes while the I hold is valid -> I hold cleared; the next held fetch re-issues mem_req.
- rst_n falls in LOCK_D with mem_ready=0 -> mem_req=0 immediately, Dwait=1; after release, D re-issues from IDLE and the transaction completes.
